seg7_scan_driver: RTL and testbench

Time-multiplexed N-digit 7-segment display driver that replaces per-digit static decoding on the board I/O path. It captures a packed vector of 5-bit glyph codes and scans the digits one at a time with a programmable dwell. Anti-ghosting blanking, leading-zero suppression, per-digit decimal points and per-digit blinking are built in. It sits between the processor's display register and the board's shared segment bus and digit-enable pins.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_glyph_rom.sv | 10 +
 rtl/seg7_scan_driver.sv | 115 +++++++++++
 tb/tb_seg7_scan_driver.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph codes, segment bit positions and the 5-bit code to a..g decode
// used by both the scanned and the static display paths.
package seg7_pkg;

   localparam logic [4:0] GLY_MINUS = 5'd16;
   localparam logic [4:0] GLY_BLANK = 5'd31;

   localparam int SEG_A  = 7;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   function automatic logic [6:0] glyph_decode(input logic [4:0] code);
      logic [6:0] segs;
      case (code)
         5'd0:      segs = 7'b1111110;
         5'd1:      segs = 7'b0110000;
         5'd2:      segs = 7'b1101101;
         5'd3:      segs = 7'b1111001;
         5'd4:      segs = 7'b0110011;
         5'd5:      segs = 7'b1011011;
         5'd6:      segs = 7'b1011111;
         5'd7:      segs = 7'b1110000;
         5'd8:      segs = 7'b1111111;
         5'd9:      segs = 7'b1111011;
         5'd10:     segs = 7'b1110111;
         5'd11:     segs = 7'b0011111;
         5'd12:     segs = 7'b0001101;
         5'd13:     segs = 7'b0111101;
         5'd14:     segs = 7'b1001111;
         5'd15:     segs = 7'b1000111;
         GLY_MINUS: segs = 7'b0000001;
         default:   segs = 7'b0000000;
      endcase
      return segs;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display register side (master) to scan driver (slave) bundle, including the
// pin-level segment bus and digit enables.
interface seg7_scan_driver_if #(
   parameter int NDIGIT = 4
);
   logic                  load;
   logic [5*NDIGIT-1:0]   value;
   logic [NDIGIT-1:0]     dp;
   logic [NDIGIT-1:0]     blink_mask;
   logic                  blank_lz;
   logic [7:0]            seg;
   logic [NDIGIT-1:0]     dig_sel;

   modport master (
      output load, value, dp, blink_mask, blank_lz,
      input  seg, dig_sel
   );

   modport slave (
      input  load, value, dp, blink_mask, blank_lz,
      output seg, dig_sel
   );
endinterface

// File: rtl/seg7_glyph_rom.sv
// Combinational glyph code to a..g segment pattern; shared with the
// single-digit static path.
module seg7_glyph_rom
   import seg7_pkg::*;
(
   input  logic [4:0] i_code,
   output logic [6:0] o_seg
);
   assign o_seg = glyph_decode(i_code);
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow registers, slot/digit/frame
// counters, leading-zero suppression, blinking and a registered pin stage.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NDIGIT       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 64,
   parameter int ACTIVE_LOW   = 0
) (
   input  logic i_clk,
   input  logic i_rst,
   seg7_scan_driver_if.slave bus_if
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;
   localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [FRM_W-1:0]  r_frm;
   logic              r_bph;
   logic [4:0]        r_code [NDIGIT];
   logic [NDIGIT-1:0] r_dp;
   logic [NDIGIT-1:0] r_blink;
   logic              r_lz;
   logic [7:0]        r_seg;
   logic [NDIGIT-1:0] r_dig;

   logic [4:0]        w_code;
   logic [6:0]        w_glyph;
   logic [NDIGIT-1:0] w_supp;
   logic              w_lz_run;
   logic [7:0]        w_seg;
   logic [NDIGIT-1:0] w_dig;
   logic              w_slot_end;
   logic              w_frame_end;

   assign w_code = r_code[r_idx];

   seg7_glyph_rom u_rom (
      .i_code (w_code),
      .o_seg  (w_glyph)
   );

   // Suppression runs from the top digit down and stops at the first non-zero
   // code; minus and blank codes are non-zero so they end the run too.
   always_comb begin
      w_supp   = '0;
      w_lz_run = r_lz;
      for (int i = NDIGIT - 1; i > 0; i--) begin
         w_lz_run  = w_lz_run & (r_code[i] == 5'd0);
         w_supp[i] = w_lz_run;
      end
   end

   always_comb begin
      w_seg = '0;
      w_dig = '0;
      if (r_cnt >= CNT_W'(BLANK_CYC)) begin
         w_dig = NDIGIT'(1) << r_idx;
         if (!(r_blink[r_idx] && !r_bph)) begin
            w_seg[SEG_DP] = r_dp[r_idx];
            if (!w_supp[r_idx])
               w_seg[SEG_A:SEG_G] = w_glyph;
         end
      end
   end

   assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NDIGIT - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_idx   <= '0;
         r_frm   <= '0;
         r_bph   <= 1'b1;
         for (int i = 0; i < NDIGIT; i++)
            r_code[i] <= GLY_BLANK;
         r_dp    <= '0;
         r_blink <= '0;
         r_lz    <= 1'b0;
         r_seg   <= '0;
         r_dig   <= '0;
      end else begin
         if (bus_if.load) begin
            for (int i = 0; i < NDIGIT; i++)
               r_code[i] <= bus_if.value[5*i +: 5];
            r_dp    <= bus_if.dp;
            r_blink <= bus_if.blink_mask;
            r_lz    <= bus_if.blank_lz;
         end
         r_seg <= w_seg;
         r_dig <= w_dig;
         r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
         if (w_slot_end)
            r_idx <= (r_idx == IDX_W'(NDIGIT - 1)) ? '0 : r_idx + 1'b1;
         if (w_frame_end) begin
            if (r_frm == FRM_W'(BLINK_FRAMES - 1)) begin
               r_frm <= '0;
               r_bph <= ~r_bph;
            end else begin
               r_frm <= r_frm + 1'b1;
            end
         end
      end
   end

   assign bus_if.seg     = (ACTIVE_LOW != 0) ? ~r_seg : r_seg;
   assign bus_if.dig_sel = (ACTIVE_LOW != 0) ? ~r_dig : r_dig;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: an active-high and an active-low driver see identical
// stimulus; expected pin values are hand-computed per cycle after reset release.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   seg7_scan_driver_if #(.NDIGIT(4)) bus_h ();
   seg7_scan_driver_if #(.NDIGIT(4)) bus_l ();

   seg7_scan_driver #(
      .NDIGIT(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .ACTIVE_LOW(0)
   ) u_dut_h (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus_if (bus_h.slave)
   );

   seg7_scan_driver #(
      .NDIGIT(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .ACTIVE_LOW(1)
   ) u_dut_l (
      .i_clk  (clk),
      .i_rst  (rst),
      .bus_if (bus_l.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   task automatic chk_both(input string tag, input logic [3:0] dig, input logic [7:0] seg);
      chk({tag, "_seg"},    bus_h.seg,              seg);
      chk({tag, "_dig"},    {4'h0, bus_h.dig_sel},  {4'h0, dig});
      chk({tag, "_seg_al"}, bus_l.seg,              ~seg);
      chk({tag, "_dig_al"}, {4'h0, bus_l.dig_sel},  {4'h0, ~dig});
   endtask

   task automatic do_load(input logic [19:0] v, input logic [3:0] d,
                          input logic [3:0] m, input logic lz);
      bus_h.value = v;  bus_h.dp = d;  bus_h.blink_mask = m;  bus_h.blank_lz = lz;
      bus_l.value = v;  bus_l.dp = d;  bus_l.blink_mask = m;  bus_l.blank_lz = lz;
      bus_h.load = 1'b1;
      bus_l.load = 1'b1;
      step();
      bus_h.load = 1'b0;
      bus_l.load = 1'b0;
   endtask

   initial begin
      bus_h.load = 1'b0;  bus_h.value = '0;  bus_h.dp = '0;
      bus_h.blink_mask = '0;  bus_h.blank_lz = 1'b0;
      bus_l.load = 1'b0;  bus_l.value = '0;  bus_l.dp = '0;
      bus_l.blink_mask = '0;  bus_l.blank_lz = 1'b0;

      #12;
      chk_both("reset", 4'b0000, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;

      step(); chk_both("rel_c1", 4'b0000, 8'h00);
      step(); chk_both("rel_c2", 4'b0000, 8'h00);
      step(); chk_both("rel_c3", 4'b0001, 8'h00);

      // {3,2,1,0}, digit 0 blinking, no suppression
      do_load({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0000, 4'b0001, 1'b0);
      goto(5);   chk_both("scan_new_data", 4'b0001, 8'hFC);
      goto(33);  chk_both("scan_dark_a",   4'b0000, 8'h00);
      goto(34);  chk_both("scan_dark_b",   4'b0000, 8'h00);
      goto(35);  chk_both("scan_d0_first", 4'b0001, 8'hFC);
      goto(40);  chk_both("scan_d0_last",  4'b0001, 8'hFC);
      goto(41);  chk_both("scan_gap",      4'b0000, 8'h00);
      goto(43);  chk_both("scan_d1",       4'b0010, 8'h60);
      goto(51);  chk_both("scan_d2",       4'b0100, 8'hDA);
      goto(56);  chk_both("scan_d2_last",  4'b0100, 8'hDA);
      goto(57);  chk_both("scan_gap2",     4'b0000, 8'h00);
      goto(59);  chk_both("scan_d3",       4'b1000, 8'hF2);

      goto(67);  chk_both("blink_f2_d0",   4'b0001, 8'h00);
      goto(75);  chk_both("blink_f2_d1",   4'b0010, 8'h60);

      // {0,0,7,0} with suppression
      goto(80);
      do_load({5'd0, 5'd0, 5'd7, 5'd0}, 4'b0000, 4'b0001, 1'b1);
      goto(99);  chk_both("blink_f3_d0",   4'b0001, 8'h00);
      goto(107); chk_both("lz_d1",         4'b0010, 8'hE0);
      goto(115); chk_both("lz_d2",         4'b0100, 8'h00);
      goto(123); chk_both("lz_d3",         4'b1000, 8'h00);
      goto(131); chk_both("blink_f4_d0",   4'b0001, 8'hFC);

      // all zeros: only digit 0 lit
      goto(136);
      do_load(20'd0, 4'b0000, 4'b0001, 1'b1);
      goto(139); chk_both("zero_d1",       4'b0010, 8'h00);
      goto(147); chk_both("zero_d2",       4'b0100, 8'h00);
      goto(155); chk_both("zero_d3",       4'b1000, 8'h00);
      goto(163); chk_both("zero_d0",       4'b0001, 8'hFC);

      // {16,0,5,31}, dp on digit 2
      goto(164);
      do_load({5'd16, 5'd0, 5'd5, 5'd31}, 4'b0100, 4'b0001, 1'b1);
      goto(171); chk_both("minus_d1",      4'b0010, 8'hB6);
      goto(179); chk_both("minus_d2",      4'b0100, 8'hFD);
      goto(187); chk_both("minus_d3",      4'b1000, 8'h02);

      // digit 0 = 8 to see the blink phase in frames 6..8
      goto(188);
      do_load({5'd16, 5'd0, 5'd5, 5'd8}, 4'b0100, 4'b0001, 1'b1);
      goto(195); chk_both("blink_f6_d0",   4'b0001, 8'h00);
      goto(203); chk_both("blink_f6_d1",   4'b0010, 8'hB6);
      goto(227); chk_both("blink_f7_d0",   4'b0001, 8'h00);
      goto(259); chk_both("blink_f8_d0",   4'b0001, 8'hFE);

      // reset mid-slot
      goto(260);
      #2;
      rst = 1'b1;
      #1;
      chk_both("rst_mid", 4'b0000, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      step(); chk_both("rst2_c1", 4'b0000, 8'h00);
      step(); chk_both("rst2_c2", 4'b0000, 8'h00);
      step(); chk_both("rst2_c3", 4'b0001, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
